// File: rtl/scarv_soc_mem_arbiter.sv
// 2:1 split-transaction memory arbiter with an in-order owner FIFO for response routing.
// Define SCARV_SOC_ARB_FIXED_PRIO_EN to give m0 fixed priority instead of round robin.
module scarv_soc_mem_arbiter #(
  parameter int OUTSTANDING = 2
) (
  input  logic        f_clk,
  input  logic        g_resetn,
  input  logic        m0_req,
  output logic        m0_gnt,
  input  logic        m0_wen,
  input  logic [3:0]  m0_strb,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_recv,
  input  logic        m0_ack,
  output logic        m0_error,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  output logic        m1_gnt,
  input  logic        m1_wen,
  input  logic [3:0]  m1_strb,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_recv,
  input  logic        m1_ack,
  output logic        m1_error,
  output logic [31:0] m1_rdata,
  output logic        s_req,
  input  logic        s_gnt,
  output logic        s_wen,
  output logic [3:0]  s_strb,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic        s_recv,
  output logic        s_ack,
  input  logic        s_error,
  input  logic [31:0] s_rdata,
  output logic        arb_err
);

  localparam int CW = $clog2(OUTSTANDING + 1);
  localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

  logic [CW-1:0] count;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          owner_q [OUTSTANDING];
  logic          lock_valid, lock_sel;
  logic          full, nonempty, sel, push, pop, head;
`ifndef SCARV_SOC_ARB_FIXED_PRIO_EN
  logic          last_grant;
`endif

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full     = (count == CW'(OUTSTANDING));
  assign nonempty = (count != '0);
  assign s_req    = (m0_req | m1_req) & ~full;
  assign push     = s_req & s_gnt;

  // A stalled request keeps its owner until the slave finally accepts it.
  always_comb begin
    sel = 1'b0;
    if (lock_valid)
      sel = lock_sel;
    else if (m0_req && m1_req)
`ifdef SCARV_SOC_ARB_FIXED_PRIO_EN
      sel = 1'b0;
`else
      sel = ~last_grant;
`endif
    else
      sel = m1_req;
  end

  assign m0_gnt  = push & ~sel;
  assign m1_gnt  = push & sel;
  assign s_wen   = sel ? m1_wen   : m0_wen;
  assign s_strb  = sel ? m1_strb  : m0_strb;
  assign s_addr  = sel ? m1_addr  : m0_addr;
  assign s_wdata = sel ? m1_wdata : m0_wdata;

  // Responses return in order, so the FIFO head names their owner; orphans are drained.
  assign head     = owner_q[rd_ptr];
  assign m0_recv  = s_recv & nonempty & ~head;
  assign m1_recv  = s_recv & nonempty & head;
  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;
  assign m0_error = s_error;
  assign m1_error = s_error;
  assign s_ack    = nonempty ? (head ? m1_ack : m0_ack) : s_recv;
  assign pop      = s_recv & s_ack & nonempty;

  always_ff @(posedge f_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      lock_valid <= 1'b0;
      lock_sel   <= 1'b0;
      arb_err    <= 1'b0;
`ifndef SCARV_SOC_ARB_FIXED_PRIO_EN
      last_grant <= 1'b1;
`endif
      for (int i = 0; i < OUTSTANDING; i++) owner_q[i] <= 1'b0;
    end else begin
      if (push) begin
        owner_q[wr_ptr] <= sel;
        wr_ptr          <= next_ptr(wr_ptr);
        lock_valid      <= 1'b0;
`ifndef SCARV_SOC_ARB_FIXED_PRIO_EN
        last_grant      <= sel;
`endif
      end else if (s_req) begin
        lock_valid <= 1'b1;
        lock_sel   <= sel;
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (s_recv && !nonempty) arb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_scarv_soc_mem_arbiter.sv
// Directed and random checks of scarv_soc_mem_arbiter against a queue-based transaction model.
module tb_scarv_soc_mem_arbiter;

  localparam int OUTSTANDING = 2;

  logic        f_clk = 1'b0;
  logic        g_resetn;
  logic        req_v [2];
  logic        wen_v [2];
  logic        ack_v [2];
  logic [3:0]  strb_v [2];
  logic [31:0] addr_v [2];
  logic [31:0] wdata_v [2];
  logic        s_gnt, s_recv, s_error;
  logic [31:0] s_rdata;
  logic        m0_gnt, m1_gnt, m0_recv, m1_recv, m0_error, m1_error;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_req, s_wen, s_ack, arb_err;
  logic [3:0]  s_strb;
  logic [31:0] s_addr, s_wdata;

  int tests_run = 0;
  int tests_failed = 0;

  // Model state: owners of accepted-but-unanswered requests, in issue order.
  int owners[$];
  int last_grant;
  bit locked;
  int lock_who;
  bit exp_arb_err;
  int renew_mode;
  int winner;
  bit e_sreq, e_ack;
  bit e_gnt [2];
  bit e_recv [2];
  logic [31:0] saved_addr;

  always #5 f_clk = ~f_clk;

  scarv_soc_mem_arbiter #(.OUTSTANDING(OUTSTANDING)) dut (
    .f_clk(f_clk), .g_resetn(g_resetn),
    .m0_req(req_v[0]), .m0_gnt(m0_gnt), .m0_wen(wen_v[0]), .m0_strb(strb_v[0]),
    .m0_addr(addr_v[0]), .m0_wdata(wdata_v[0]), .m0_recv(m0_recv), .m0_ack(ack_v[0]),
    .m0_error(m0_error), .m0_rdata(m0_rdata),
    .m1_req(req_v[1]), .m1_gnt(m1_gnt), .m1_wen(wen_v[1]), .m1_strb(strb_v[1]),
    .m1_addr(addr_v[1]), .m1_wdata(wdata_v[1]), .m1_recv(m1_recv), .m1_ack(ack_v[1]),
    .m1_error(m1_error), .m1_rdata(m1_rdata),
    .s_req(s_req), .s_gnt(s_gnt), .s_wen(s_wen), .s_strb(s_strb), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_recv(s_recv), .s_ack(s_ack), .s_error(s_error),
    .s_rdata(s_rdata), .arb_err(arb_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic new_req(input int i);
    req_v[i]   = 1'b1;
    wen_v[i]   = 1'($urandom);
    strb_v[i]  = 4'($urandom);
    addr_v[i]  = $urandom;
    wdata_v[i] = $urandom;
  endtask

  // Predict this cycle's outputs from the model and compare.
  task automatic eval();
    #2;
    e_sreq = (req_v[0] || req_v[1]) && (owners.size() < OUTSTANDING);
    if (locked) winner = lock_who;
    else if (req_v[0] && req_v[1])
`ifdef SCARV_SOC_ARB_FIXED_PRIO_EN
      winner = 0;
`else
      winner = 1 - last_grant;
`endif
    else winner = req_v[1] ? 1 : 0;
    e_gnt[0] = e_sreq && s_gnt && winner == 0;
    e_gnt[1] = e_sreq && s_gnt && winner == 1;
    e_recv[0] = 1'b0;
    e_recv[1] = 1'b0;
    if (owners.size() > 0) begin
      e_recv[owners[0]] = s_recv;
      e_ack = ack_v[owners[0]];
    end else e_ack = s_recv;
    check("s_req", s_req, e_sreq);
    check("m0_gnt", m0_gnt, e_gnt[0]);
    check("m1_gnt", m1_gnt, e_gnt[1]);
    check("m0_recv", m0_recv, e_recv[0]);
    check("m1_recv", m1_recv, e_recv[1]);
    check("s_ack", s_ack, e_ack);
    check("arb_err", arb_err, exp_arb_err);
    if (e_sreq) begin
      check("s_addr", s_addr, addr_v[winner]);
      check("s_wdata", s_wdata, wdata_v[winner]);
      check("s_wen", s_wen, wen_v[winner]);
      check("s_strb", s_strb, strb_v[winner]);
    end
    if (e_recv[0]) begin
      check("m0_rdata", m0_rdata, s_rdata);
      check("m0_error", m0_error, s_error);
    end
    if (e_recv[1]) begin
      check("m1_rdata", m1_rdata, s_rdata);
      check("m1_error", m1_error, s_error);
    end
  endtask

  // Advance the model by one clock, then refresh master requests after the edge.
  task automatic commit();
    if (s_recv && owners.size() == 0) exp_arb_err = 1'b1;
    if (s_recv && e_ack && owners.size() > 0) void'(owners.pop_front());
    if (e_gnt[winner]) begin
      owners.push_back(winner);
      last_grant = winner;
      locked = 1'b0;
    end else if (e_sreq) begin
      locked = 1'b1;
      lock_who = winner;
    end
    @(posedge f_clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (e_gnt[i]) begin
        if (renew_mode == 1 || (renew_mode == 2 && $urandom_range(0, 1) == 1)) new_req(i);
        else req_v[i] = 1'b0;
      end else if (!req_v[i] && renew_mode == 2 && $urandom_range(0, 2) == 0) new_req(i);
    end
  endtask

  task automatic step();
    eval();
    commit();
  endtask

  task automatic drain();
    req_v[0] = 1'b0; req_v[1] = 1'b0;
    s_gnt = 1'b0; s_recv = 1'b1; ack_v[0] = 1'b1; ack_v[1] = 1'b1;
    for (int k = 0; k < 8; k++) if (owners.size() > 0) step();
    s_recv = 1'b0;
  endtask

  // Masters and slave are reset together with the arbiter.
  task automatic do_reset();
    req_v[0] = 1'b0; req_v[1] = 1'b0; s_gnt = 1'b0; s_recv = 1'b0;
    g_resetn = 1'b0;
    #1;
    check("rst_s_req", s_req, 1'b0);
    check("rst_m0_gnt", m0_gnt, 1'b0);
    check("rst_m1_gnt", m1_gnt, 1'b0);
    check("rst_m0_recv", m0_recv, 1'b0);
    check("rst_m1_recv", m1_recv, 1'b0);
    check("rst_s_ack", s_ack, 1'b0);
    check("rst_arb_err", arb_err, 1'b0);
    owners.delete();
    last_grant = 1; locked = 1'b0; exp_arb_err = 1'b0;
    @(posedge f_clk);
    #1;
    g_resetn = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      req_v[i] = 1'b0; wen_v[i] = 1'b0; ack_v[i] = 1'b0;
      strb_v[i] = '0; addr_v[i] = '0; wdata_v[i] = '0;
    end
    s_gnt = 1'b0; s_recv = 1'b0; s_error = 1'b0; s_rdata = '0;
    renew_mode = 0; last_grant = 1; locked = 1'b0; exp_arb_err = 1'b0;
    g_resetn = 1'b0;
    @(posedge f_clk); #1;
    g_resetn = 1'b1;

    // Reset in the middle of a stalled m1 request, then contention goes to m0.
    new_req(1);
    step(); step();
    do_reset();
    new_req(0); new_req(1); s_gnt = 1'b1;
    eval();
    check("first_gnt_m0", m0_gnt, 1'b1);
    commit();

    // Continuous contention with responses flowing.
    renew_mode = 1; new_req(0); s_recv = 1'b1; ack_v[0] = 1'b1; ack_v[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      eval();
`ifdef SCARV_SOC_ARB_FIXED_PRIO_EN
      check("prio_m0_gnt", m0_gnt, 1'b1);
`else
      check("rr_m1_gnt", m1_gnt, (i % 2 == 0) ? 1'b1 : 1'b0);
`endif
      commit();
    end
    renew_mode = 0;
    drain();

    // Stalled m1 request stays locked even when m0 arrives.
    s_gnt = 1'b0; new_req(1); saved_addr = addr_v[1];
    for (int c = 1; c <= 3; c++) begin
      if (c == 2) new_req(0);
      eval();
      check("lock_addr", s_addr, saved_addr);
      check("lock_m0_gnt", m0_gnt, 1'b0);
      commit();
    end
    s_gnt = 1'b1;
    eval();
    check("lock_m1_gnt", m1_gnt, 1'b1);
    commit();
    eval();
    check("after_lock_m0_gnt", m0_gnt, 1'b1);
    commit();

    // FIFO full blocks grants, even in the cycle of a pop.
    new_req(0);
    eval();
    check("full_s_req", s_req, 1'b0);
    check("full_m0_gnt", m0_gnt, 1'b0);
    commit();
    s_recv = 1'b1; ack_v[0] = 1'b1; ack_v[1] = 1'b1;
    eval();
    check("full_pop_m0_gnt", m0_gnt, 1'b0);
    commit();
    s_recv = 1'b0;
    eval();
    check("resume_m0_gnt", m0_gnt, 1'b1);
    commit();
    drain();

    // In-order routing of read responses, with an m1 ack stall.
    s_gnt = 1'b1; new_req(0);
    step();
    new_req(1);
    step();
    s_gnt = 1'b0; s_recv = 1'b1; s_rdata = 32'hAAAA_AAAA; ack_v[0] = 1'b1; ack_v[1] = 1'b1;
    eval();
    check("order_m0_recv", m0_recv, 1'b1);
    check("order_m0_rdata", m0_rdata, 32'hAAAA_AAAA);
    check("order_m1_recv0", m1_recv, 1'b0);
    commit();
    s_rdata = 32'h5555_5555; ack_v[1] = 1'b0;
    eval();
    check("order_m1_recv", m1_recv, 1'b1);
    check("stall_s_ack", s_ack, 1'b0);
    commit();
    ack_v[1] = 1'b1;
    eval();
    check("order_s_ack", s_ack, 1'b1);
    check("order_m1_rdata", m1_rdata, 32'h5555_5555);
    commit();

    // Orphan response is drained and flagged stickily.
    s_recv = 1'b1; ack_v[0] = 1'b0; ack_v[1] = 1'b0;
    eval();
    check("orphan_s_ack", s_ack, 1'b1);
    check("orphan_m0_recv", m0_recv, 1'b0);
    check("orphan_m1_recv", m1_recv, 1'b0);
    commit();
    s_recv = 1'b0;
    eval();
    check("arb_err_set", arb_err, 1'b1);
    commit();
    step();

    // Random traffic against the model.
    do_reset();
    renew_mode = 2;
    for (int n = 0; n < 400; n++) begin
      s_gnt   = ($urandom_range(0, 3) != 0);
      s_recv  = ($urandom_range(0, 2) == 0);
      ack_v[0] = ($urandom_range(0, 3) != 0);
      ack_v[1] = ($urandom_range(0, 3) != 0);
      s_rdata = $urandom;
      s_error = 1'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
